// File: rtl/unloader_word_buffer_pkg.sv
// Shared definitions for the loader/unloader word buffer blocks.
//   state_t         : word-buffer FSM states
//   LINE_W          : width of the buffered line (two 16-bit memory words)
//   TIMEOUT_DEFAULT : default per-beat wait limit for mem_ack
//   line_byte()     : little-endian byte select out of a line
package unloader_word_buffer_pkg;

   localparam int LINE_W          = 32;
   localparam int TIMEOUT_DEFAULT = 16;
   localparam int ADDR_W          = 28;
   localparam int WADDR_W         = 27;
   localparam int TAG_W           = 26;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_LO,
      WAIT_LO,
      FETCH_HI,
      WAIT_HI,
      RESPOND
   } state_t;

   // Byte n of the line sits in bits 8n+7:8n.
   function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] line,
                                            input logic [1:0]        sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = line[7:0];
         2'd1:    b = line[15:8];
         2'd2:    b = line[23:16];
         default: b = line[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/unloader_word_buffer.sv
// One-line (32-bit) read buffer between the data unloader (byte reads) and a
// 16-bit word memory. A hit answers in one cycle; a miss fetches the low and
// high words of the line and then answers. A beat that is not acknowledged
// within TIMEOUT cycles is answered with 8'h00 and flagged.
// Ports:
//   clk_memory, reset          : clock, synchronous active-high reset
//   read_en/read_addr          : byte read request (accepted only in IDLE)
//   read_data/read_valid       : byte response, read_valid is a 1-cycle pulse
//   invalidate                 : drops the buffered line
//   mem_rd/mem_addr            : word read request, mem_addr held per beat
//   mem_ack/mem_data           : word response
//   err_timeout/err_overrun    : sticky error flags, cleared only by reset
module unloader_word_buffer
   import unloader_word_buffer_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic               clk_memory,
   input  logic               reset,
   input  logic               read_en,
   input  logic [ADDR_W-1:0]  read_addr,
   output logic [7:0]         read_data,
   output logic               read_valid,
   input  logic               invalidate,
   output logic               mem_rd,
   output logic [WADDR_W-1:0] mem_addr,
   input  logic               mem_ack,
   input  logic [15:0]        mem_data,
   output logic               err_timeout,
   output logic               err_overrun
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t               state_q, state_d;
   logic                 valid_q, valid_d;
   logic                 inv_pend_q, inv_pend_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           read_data_q, read_data_d;
   logic                 read_valid_q, read_valid_d;
   logic                 mem_rd_q, mem_rd_d;
   logic [WADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                 err_timeout_q, err_timeout_d;
   logic                 err_overrun_q, err_overrun_d;
   logic [TAG_W-1:0]     tag_q, tag_d;
   logic [LINE_W-1:0]    line_q, line_d;
   logic [TAG_W-1:0]     req_tag_q, req_tag_d;
   logic [1:0]           req_sel_q, req_sel_d;

   logic                 in_wait;
   logic                 hit;
   logic                 beat_expired;

   assign in_wait      = (state_q == WAIT_LO) || (state_q == WAIT_HI);
   // A coincident invalidate turns the read into a miss.
   assign hit          = read_en && valid_q && !invalidate &&
                         (read_addr[ADDR_W-1:2] == tag_q);
   assign beat_expired = in_wait && !mem_ack && (cnt_q == CNT_LAST);

   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      inv_pend_d    = inv_pend_q;
      read_data_d   = read_data_q;
      read_valid_d  = 1'b0;
      mem_rd_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      err_timeout_d = err_timeout_q;
      err_overrun_d = err_overrun_q;
      tag_d         = tag_q;
      line_d        = line_q;
      req_tag_d     = req_tag_q;
      req_sel_d     = req_sel_q;
      // Counts consecutive un-acknowledged cycles of the current beat.
      cnt_d         = (in_wait && !mem_ack) ? cnt_q + CNT_W'(1) : '0;

      if (invalidate) begin
         valid_d = 1'b0;
         // Remember it so the line being fetched is not marked valid.
         if (state_q != IDLE) inv_pend_d = 1'b1;
      end
      // Requests outside IDLE are dropped, not queued.
      if (read_en && (state_q != IDLE)) err_overrun_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (read_en) begin
               req_tag_d = read_addr[ADDR_W-1:2];
               req_sel_d = read_addr[1:0];
               if (hit) begin
                  read_data_d  = line_byte(line_q, read_addr[1:0]);
                  read_valid_d = 1'b1;
               end else begin
                  state_d    = FETCH_LO;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = {read_addr[ADDR_W-1:2], 1'b0};
                  inv_pend_d = 1'b0;
               end
            end
         end
         FETCH_LO: state_d = WAIT_LO;
         WAIT_LO: begin
            if (mem_ack) begin
               line_d[15:0] = mem_data;
               state_d      = FETCH_HI;
               mem_rd_d     = 1'b1;
               mem_addr_d   = {req_tag_q, 1'b1};
            end else if (beat_expired) begin
               read_data_d   = 8'h00;
               read_valid_d  = 1'b1;
               valid_d       = 1'b0;
               err_timeout_d = 1'b1;
               state_d       = IDLE;
            end
         end
         FETCH_HI: state_d = WAIT_HI;
         WAIT_HI: begin
            if (mem_ack) begin
               line_d[31:16] = mem_data;
               tag_d         = req_tag_q;
               valid_d       = !(inv_pend_q || invalidate);
               state_d       = RESPOND;
            end else if (beat_expired) begin
               read_data_d   = 8'h00;
               read_valid_d  = 1'b1;
               valid_d       = 1'b0;
               err_timeout_d = 1'b1;
               state_d       = IDLE;
            end
         end
         RESPOND: begin
            read_data_d  = line_byte(line_q, req_sel_q);
            read_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_memory) begin
      if (reset) begin
         state_q       <= IDLE;
         valid_q       <= 1'b0;
         inv_pend_q    <= 1'b0;
         cnt_q         <= '0;
         read_data_q   <= 8'h00;
         read_valid_q  <= 1'b0;
         mem_rd_q      <= 1'b0;
         mem_addr_q    <= '0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         inv_pend_q    <= inv_pend_d;
         cnt_q         <= cnt_d;
         read_data_q   <= read_data_d;
         read_valid_q  <= read_valid_d;
         mem_rd_q      <= mem_rd_d;
         mem_addr_q    <= mem_addr_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   // Line contents and request tags are qualified by valid_q / state_q.
   always_ff @(posedge clk_memory) begin
      tag_q     <= tag_d;
      line_q    <= line_d;
      req_tag_q <= req_tag_d;
      req_sel_q <= req_sel_d;
   end

   assign read_data   = read_data_q;
   assign read_valid  = read_valid_q;
   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_unloader_word_buffer.sv
// Directed bench for unloader_word_buffer: a vector table of byte reads
// against a word memory model with programmable ack delay, plus hand-written
// timeout and reset-mid-fetch sequences.
module tb_unloader_word_buffer;

   localparam int RD_LIMIT = 40;

   logic        clk_memory = 1'b0;
   logic        reset      = 1'b1;
   logic        read_en    = 1'b0;
   logic [27:0] read_addr  = '0;
   logic [7:0]  read_data;
   logic        read_valid;
   logic        invalidate = 1'b0;
   logic        mem_rd;
   logic [26:0] mem_addr;
   logic        mem_ack    = 1'b0;
   logic [15:0] mem_data   = '0;
   logic        err_timeout;
   logic        err_overrun;

   int n_checks = 0;
   int n_fail   = 0;

   int          mem_dly = 1;   // 0: never ack
   int          cd      = 0;
   int          rd_cnt  = 0;
   int          rv_cnt  = 0;
   logic [26:0] addr_log[$];

   unloader_word_buffer #(.TIMEOUT(16)) dut (
      .clk_memory (clk_memory),
      .reset      (reset),
      .read_en    (read_en),
      .read_addr  (read_addr),
      .read_data  (read_data),
      .read_valid (read_valid),
      .invalidate (invalidate),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_data   (mem_data),
      .err_timeout(err_timeout),
      .err_overrun(err_overrun)
   );

   always #5 clk_memory = ~clk_memory;

   function automatic logic [15:0] mem_word(input logic [26:0] wa);
      case (wa)
         27'h0000006: return 16'hBBAA;
         27'h0000007: return 16'hDDCC;
         27'h7FFFFFE: return 16'h1122;
         27'h7FFFFFF: return 16'h3344;
         default:     return {~wa[7:0], wa[7:0] ^ 8'hA5};
      endcase
   endfunction

   // Memory model and pulse monitor, on the falling edge.
   initial begin
      forever begin
         @(negedge clk_memory);
         mem_ack = 1'b0;
         if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
               mem_ack  = 1'b1;
               mem_data = mem_word(mem_addr);
            end
         end
         if (mem_rd) begin
            cd     = mem_dly;
            rd_cnt = rd_cnt + 1;
            addr_log.push_back(mem_addr);
         end
         if (read_valid) rv_cnt = rv_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_read(input logic [27:0] addr, input int dly, input int inv_cyc,
                          input int ovr_cyc, output logic [7:0] data, output int lat,
                          output int nrd, output int nrv,
                          output logic [26:0] wa0, output logic [26:0] wa1);
      int rd0, rv0;
      mem_dly = dly;
      rd0 = rd_cnt;
      rv0 = rv_cnt;
      addr_log.delete();
      read_addr  = addr;
      read_en    = 1'b1;
      invalidate = (inv_cyc == 0);
      lat = 0;
      do begin
         @(posedge clk_memory); #1;
         lat++;
         read_en    = (lat == ovr_cyc);
         read_addr  = (lat == ovr_cyc) ? (addr ^ 28'h40) : addr;
         invalidate = (lat == inv_cyc);
      end while (!read_valid && lat < RD_LIMIT);
      data = read_data;
      if (!read_valid) lat = -1;
      read_en    = 1'b0;
      invalidate = 1'b0;
      repeat (3) begin @(posedge clk_memory); #1; end
      nrd = rd_cnt - rd0;
      nrv = rv_cnt - rv0;
      wa0 = (addr_log.size() > 0) ? addr_log[0] : '1;
      wa1 = (addr_log.size() > 1) ? addr_log[1] : '1;
   endtask

   typedef struct {
      logic [27:0] addr;
      int          dly;
      int          inv_cyc;
      int          ovr_cyc;
      logic [7:0]  exp_data;
      int          exp_lat;
      int          exp_nrd;
      logic [26:0] exp_waddr;
   } vec_t;

   vec_t vecs[15];

   initial begin
      logic [7:0]  d;
      int          lat, nrd, nrv;
      logic [26:0] wa0, wa1;
      logic        ovr_seen;
      int          rd0, rv0, cyc;

      //          addr         dly inv ovr data   lat nrd waddr
      vecs[0]  = '{28'h000000C, 1, -1, -1, 8'hAA, 6,  2, 27'h0000006};
      vecs[1]  = '{28'h000000D, 1, -1, -1, 8'hBB, 1,  0, 27'h0};
      vecs[2]  = '{28'h000000E, 1, -1, -1, 8'hCC, 1,  0, 27'h0};
      vecs[3]  = '{28'h000000F, 1, -1, -1, 8'hDD, 1,  0, 27'h0};
      vecs[4]  = '{28'h000000C, 1, -1, -1, 8'hAA, 1,  0, 27'h0};
      vecs[5]  = '{28'h0000124, 1, -1, -1, 8'h37, 6,  2, 27'h0000092};
      vecs[6]  = '{28'h0000127, 1, -1, -1, 8'h6C, 1,  0, 27'h0};
      vecs[7]  = '{28'hFFFFFFF, 1, -1, -1, 8'h33, 6,  2, 27'h7FFFFFE};
      vecs[8]  = '{28'hFFFFFFC, 1, -1, -1, 8'h22, 1,  0, 27'h0};
      vecs[9]  = '{28'h0000300, 4, -1,  3, 8'h25, 12, 2, 27'h0000180};
      vecs[10] = '{28'h0000301, 1, -1, -1, 8'h7F, 1,  0, 27'h0};
      vecs[11] = '{28'h0000301, 1,  0, -1, 8'h7F, 6,  2, 27'h0000180};
      vecs[12] = '{28'h0000301, 1, -1, -1, 8'h7F, 1,  0, 27'h0};
      vecs[13] = '{28'h0000500, 1,  2, -1, 8'h25, 6,  2, 27'h0000280};
      vecs[14] = '{28'h0000500, 1, -1, -1, 8'h25, 6,  2, 27'h0000280};

      // Reset state
      repeat (3) @(posedge clk_memory);
      #1;
      check("rst_read_valid", 32'(read_valid), 32'd0);
      check("rst_read_data", 32'(read_data), 32'h00);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_err_timeout", 32'(err_timeout), 32'd0);
      check("rst_err_overrun", 32'(err_overrun), 32'd0);
      reset = 1'b0;
      @(posedge clk_memory); #1;

      ovr_seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         do_read(vecs[i].addr, vecs[i].dly, vecs[i].inv_cyc, vecs[i].ovr_cyc,
                 d, lat, nrd, nrv, wa0, wa1);
         if (vecs[i].ovr_cyc >= 0) ovr_seen = 1'b1;
         check($sformatf("v%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d_mem_rd_count", i), 32'(nrd), 32'(vecs[i].exp_nrd));
         check($sformatf("v%0d_read_valid_count", i), 32'(nrv), 32'd1);
         check($sformatf("v%0d_err_overrun", i), 32'(err_overrun), 32'(ovr_seen));
         check($sformatf("v%0d_err_timeout", i), 32'(err_timeout), 32'd0);
         if (vecs[i].exp_nrd == 2) begin
            check($sformatf("v%0d_waddr_lo", i), 32'(wa0), 32'(vecs[i].exp_waddr));
            check($sformatf("v%0d_waddr_hi", i), 32'(wa1), 32'(vecs[i].exp_waddr + 27'd1));
         end
      end

      // Timeout in WAIT_LO: FETCH_LO + 16 WAIT_LO cycles, answer on cycle 18.
      do_read(28'h0000200, 0, -1, -1, d, lat, nrd, nrv, wa0, wa1);
      check("to_data", 32'(d), 32'h00);
      check("to_latency", 32'(lat), 32'd18);
      check("to_mem_rd_count", 32'(nrd), 32'd1);
      check("to_read_valid_count", 32'(nrv), 32'd1);
      check("to_err_timeout", 32'(err_timeout), 32'd1);
      check("to_err_overrun_sticky", 32'(err_overrun), 32'd1);
      do_read(28'h0000200, 1, -1, -1, d, lat, nrd, nrv, wa0, wa1);
      check("to_refetch_data", 32'(d), 32'hA5);
      check("to_refetch_latency", 32'(lat), 32'd6);
      check("to_refetch_mem_rd_count", 32'(nrd), 32'd2);
      check("to_err_timeout_sticky", 32'(err_timeout), 32'd1);

      // Reset while in WAIT_HI; the memory acks two cycles after reset.
      mem_dly = 4;
      rd0 = rd_cnt;
      rv0 = rv_cnt;
      read_addr = 28'h0000040;
      read_en = 1'b1;
      @(posedge clk_memory); #1;
      read_en = 1'b0;
      cyc = 0;
      while (rd_cnt < rd0 + 2 && cyc < RD_LIMIT) begin
         @(posedge clk_memory); #1;
         cyc++;
      end
      check("rm_second_beat_issued", 32'(rd_cnt - rd0), 32'd2);
      @(posedge clk_memory); #1;
      reset = 1'b1;
      @(posedge clk_memory); #1;
      reset = 1'b0;
      check("rm_read_valid", 32'(read_valid), 32'd0);
      check("rm_read_data", 32'(read_data), 32'h00);
      check("rm_mem_rd", 32'(mem_rd), 32'd0);
      check("rm_mem_addr", 32'(mem_addr), 32'd0);
      check("rm_err_timeout", 32'(err_timeout), 32'd0);
      check("rm_err_overrun", 32'(err_overrun), 32'd0);
      repeat (8) begin @(posedge clk_memory); #1; end
      check("rm_no_read_valid", 32'(rv_cnt - rv0), 32'd0);
      check("rm_no_extra_mem_rd", 32'(rd_cnt - rd0), 32'd2);
      do_read(28'h000000C, 1, -1, -1, d, lat, nrd, nrv, wa0, wa1);
      check("rm_after_data", 32'(d), 32'hAA);
      check("rm_after_latency", 32'(lat), 32'd6);
      check("rm_after_mem_rd_count", 32'(nrd), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
